// File: rtl/noc_pkg.sv
// NoC router shared definitions.
// Flit type codes, port indices and XY route helper.
package noc_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam int P_LOCAL = 0;
  localparam int P_N     = 1;
  localparam int P_E     = 2;
  localparam int P_S     = 3;
  localparam int P_W     = 4;

  localparam int DX_LSB = 2;
  localparam int DY_LSB = 0;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } ip_state_t;

  // X is resolved fully before Y, so packets never turn back into X.
  function automatic logic [4:0] xy_route(
    input logic [1:0] dx,
    input logic [1:0] dy,
    input logic [1:0] cx,
    input logic [1:0] cy
  );
    logic [4:0] r;
    r = '0;
    if (dx > cx)      r[P_E]     = 1'b1;
    else if (dx < cx) r[P_W]     = 1'b1;
    else if (dy > cy) r[P_N]     = 1'b1;
    else if (dy < cy) r[P_S]     = 1'b1;
    else              r[P_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// Input-port link: upstream flit handshake,
// arbiter request/grant and crossbar output.
interface noc_input_port_if #(
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        req;
  logic [4:0]        gnt;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              drop_err;

  modport master (
    output in_flit, in_valid, gnt,
    input  in_ready, req, out_flit,
    input  out_valid, drop_err
  );

  modport slave (
    input  in_flit, in_valid, gnt,
    output in_ready, req, out_flit,
    output out_valid, drop_err
  );
endinterface

// File: rtl/flit_fifo.sv
// Small synchronous flit FIFO.
// Head is read straight from the RAM.
module flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic [FLIT_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO, XY route on head,
// held one-hot request, packet streaming on grant.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 3,
  parameter int CUR_Y  = 1
) (
  input logic             clk,
  input logic             rst,
  noc_input_port_if.slave port
);
  localparam logic [1:0] CX = 2'(CUR_X);
  localparam logic [1:0] CY = 2'(CUR_Y);

  ip_state_t         state_q;
  ip_state_t         state_d;
  logic [4:0]        req_q;
  logic [4:0]        req_d;
  logic [4:0]        route;
  logic [FLIT_W-1:0] head;
  logic [1:0]        ftype;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic              fwd;
  logic              drop;
  logic              is_head;
  logic              is_last;

  assign push = port.in_valid & ~full;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (port.in_flit),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  assign ftype   = head[FLIT_W-1 -: 2];
  assign is_head = (ftype == FT_HEAD) |
                   (ftype == FT_SINGLE);
  assign is_last = (ftype == FT_TAIL) |
                   (ftype == FT_SINGLE);
  assign route   = xy_route(head[DX_LSB +: 2],
                            head[DY_LSB +: 2],
                            CX, CY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    fwd     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (is_head) begin
            req_d   = route;
            state_d = S_ACTIVE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        // Grant bits outside req_q never pop a flit.
        fwd = (|(req_q & port.gnt)) & ~empty;
        if (fwd && is_last) begin
          req_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = '0;
      end
    endcase
  end

  assign pop = fwd | drop;

  assign port.in_ready  = ~full;
  assign port.req       = req_q;
  assign port.out_flit  = head;
  assign port.out_valid = fwd;
  assign port.drop_err  = drop;

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at CUR=(3,1).
// Grant model: registered copy of req, maskable.
module tb_noc_input_port;
  import noc_pkg::*;

  typedef struct {
    logic [15:0] f;
    logic [4:0]  r;
  } exp_t;

  logic clk;
  logic rst;
  logic gnt_en;
  int   vecs;
  int   errs;
  exp_t exp_q[$];

  logic [4:0] rq [0:31];
  logic       ov [0:31];
  logic       ir [0:31];
  logic       dr [0:31];

  noc_input_port_if #(.FLIT_W(16)) bus ();

  noc_input_port #(
    .FLIT_W (16),
    .DEPTH  (4),
    .CUR_X  (3),
    .CUR_Y  (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !gnt_en) bus.gnt <= '0;
    else                bus.gnt <= bus.req;
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pop_unexpected: flit %h req %b, none required",
                 bus.out_flit, bus.req);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_flit !== e.f || bus.req !== e.r) begin
          errs++;
          $display("FAIL pop: flit %h req %b, required flit %h req %b",
                   bus.out_flit, bus.req, e.f, e.r);
        end
      end
    end
  end

  function automatic logic [15:0] mk(
    input logic [1:0] t,
    input logic [9:0] p,
    input logic [1:0] x,
    input logic [1:0] y
  );
    return {t, p, x, y};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [15:0] f,
                           input logic [4:0]  r);
    logic acc;
    acc = 1'b0;
    bus.in_flit  = f;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) exp_q.push_back('{f, r});
      step();
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain", exp_q.size(), 32'd0);
    step();
    step();
  endtask

  // Hand-derived routes for CUR=(3,1): X never exceeds 3.
  function automatic logic [4:0] exp_route(
    input int x,
    input int y
  );
    if (x < 3)      return 5'b10000;
    else if (y > 1) return 5'b00010;
    else if (y < 1) return 5'b01000;
    else            return 5'b00001;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] f [0:4];
    logic        ok_ir;
    logic        ok_rq;
    logic        any_ov;
    logic        tail_acc;
    logic [6:0]  ovw;

    vecs = 0;
    errs = 0;
    rst = 1'b1;
    gnt_en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  32'd1);
    chk("rst_req",       bus.req,       32'd0);
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_drop_err",  bus.drop_err,  32'd0);
    step();
    rst = 1'b0;

    // Single flit to this router: local port.
    bus.in_flit  = mk(FT_SINGLE, 10'h011, 2'd3, 2'd1);
    bus.in_valid = 1'b1;
    exp_q.push_back('{bus.in_flit, 5'b00001});
    step();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      rq[c] = bus.req;
      ov[c] = bus.out_valid;
      step();
    end
    chk("t1_req_c1", rq[1], 32'd0);
    chk("t1_req_c2", rq[2], 32'h01);
    chk("t1_ov_c2",  ov[2], 32'd0);
    chk("t1_ov_c3",  ov[3], 32'd1);
    chk("t1_req_c4", rq[4], 32'd0);
    drain();

    // Four-flit packet west.
    f[0] = mk(FT_HEAD, 10'h021, 2'd0, 2'd1);
    f[1] = mk(FT_BODY, 10'h022, 2'd2, 2'd2);
    f[2] = mk(FT_BODY, 10'h023, 2'd1, 2'd3);
    f[3] = mk(FT_TAIL, 10'h024, 2'd0, 2'd0);
    for (int c = 0; c <= 8; c++) begin
      bus.in_valid = (c < 4);
      if (c < 4) begin
        bus.in_flit = f[c];
        exp_q.push_back('{f[c], 5'b10000});
      end
      @(negedge clk);
      rq[c] = bus.req;
      ov[c] = bus.out_valid;
      step();
    end
    bus.in_valid = 1'b0;
    ovw = {ov[2], ov[3], ov[4], ov[5], ov[6], ov[7], 1'b0};
    chk("t2_ov_c2to7", ovw, 32'b0111100);
    chk("t2_req_c2", rq[2], 32'h10);
    chk("t2_req_c6", rq[6], 32'h10);
    chk("t2_req_c7", rq[7], 32'd0);
    drain();

    // Route sweep over every destination.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        push_flit(mk(FT_SINGLE, 10'(16 * x + y),
                     2'(x), 2'(y)),
                  exp_route(x, y));
      end
    end
    drain();

    // Grant withheld while FIFO fills.
    gnt_en = 1'b0;
    f[0] = mk(FT_HEAD, 10'h031, 2'd0, 2'd1);
    f[1] = mk(FT_BODY, 10'h032, 2'd0, 2'd0);
    f[2] = mk(FT_BODY, 10'h033, 2'd0, 2'd0);
    f[3] = mk(FT_BODY, 10'h034, 2'd0, 2'd0);
    f[4] = mk(FT_TAIL, 10'h035, 2'd0, 2'd0);
    ok_ir = 1'b1;
    ok_rq = 1'b1;
    any_ov = 1'b0;
    tail_acc = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      if (c <= 4) begin
        bus.in_valid = 1'b1;
        bus.in_flit  = f[c];
        exp_q.push_back('{f[c], 5'b10000});
      end
      if (c == 14) gnt_en = 1'b1;
      if (tail_acc) bus.in_valid = 1'b0;
      @(negedge clk);
      ov[c] = bus.out_valid;
      ir[c] = bus.in_ready;
      if (c >= 4 && c <= 13) begin
        ok_ir  &= ~bus.in_ready;
        ok_rq  &= (bus.req == 5'b10000);
        any_ov |= bus.out_valid;
      end
      if (c >= 4 && bus.in_valid && bus.in_ready)
        tail_acc = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    chk("t4_full_ready_low", ok_ir,  32'd1);
    chk("t4_req_held",       ok_rq,  32'd1);
    chk("t4_no_ov_wait",     any_ov, 32'd0);
    chk("t4_ready_c15",      ir[15], 32'd0);
    chk("t4_ready_c16",      ir[16], 32'd1);
    ovw = {ov[14], ov[15], ov[16], ov[17],
           ov[18], ov[19], ov[20]};
    chk("t4_ov_c14to20", ovw, 32'b0111110);
    chk("t4_tail_taken", tail_acc, 32'd1);
    drain();

    // Stray body flit is discarded.
    bus.in_flit  = mk(FT_BODY, 10'h041, 2'd0, 2'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      dr[c] = bus.drop_err;
      rq[c] = bus.req;
      ov[c] = bus.out_valid;
      step();
    end
    chk("t5_drop_c1", dr[1], 32'd1);
    chk("t5_drop_c2", dr[2], 32'd0);
    chk("t5_req_c2",  rq[2], 32'd0);
    chk("t5_ov",      {ov[1], ov[2], ov[3]}, 32'd0);
    push_flit(mk(FT_SINGLE, 10'h055, 2'd3, 2'd0), 5'b01000);
    drain();

    // Reset mid-packet flushes the FIFO.
    bus.in_flit  = mk(FT_HEAD, 10'h071, 2'd3, 2'd3);
    bus.in_valid = 1'b1;
    step();
    bus.in_flit  = mk(FT_BODY, 10'h072, 2'd0, 2'd0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_req_before_rst", bus.req, 32'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req_after_rst",   bus.req,      32'd0);
    chk("t6_ready_after_rst", bus.in_ready, 32'd1);
    step();
    push_flit(mk(FT_SINGLE, 10'h081, 2'd2, 2'd2), 5'b10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Router input-port stage: buffers incoming flits in a small synchronous FIFO and runs XY route computation on each head flit. It drives a held, one-hot request to the five per-output-port round-robin-free priority arbiters, then streams the packet out while the matching grant is high. It sits directly upstream of the output arbiters and the crossbar.

## Interface
- `FLIT_W`, 16: flit width. Bits [FLIT_W-1:FLIT_W-2] hold the type. Head flit: dest X in [3:2], dest Y in [1:0].
- `DEPTH`, 4: FIFO depth in flits, power of two, ≥2.
- `CUR_X`, 3: this router's X coordinate (2-bit).
- `CUR_Y`, 1: this router's Y coordinate (2-bit).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_flit` in FLIT_W: incoming flit.
- `in_valid` in 1: in_flit valid this cycle.
- `in_ready` out 1: FIFO not full. A push happens when in_valid & in_ready.
- `req` out 5: one-hot output-port request. Bit 0 local, 1 north, 2 east, 3 south, 4 west. Wires to the arbiters' req_0..req_4 for this input.
- `gnt` in 5: grant from the arbiters, aligned to req bits.
- `out_flit` out FLIT_W: FIFO head flit, to the crossbar.
- `out_valid` out 1: pop strobe. out_flit is transferred this cycle.
- `drop_err` out 1: one-cycle pulse when a non-head flit is discarded.

## Operation
- Flit types: 2'b00 body, 2'b01 head, 2'b10 tail, 2'b11 single (head+tail).
- XY route on the FIFO head flit, evaluated in priority order:
  - dx>CUR_X → east.
  - dx<CUR_X → west.
  - dy>CUR_Y → north.
  - dy<CUR_Y → south.
  - Otherwise → local.
- FSM states IDLE, ACTIVE. Reset state IDLE, req_q=0.
- IDLE:
  - FIFO empty → stay.
  - Head type is head or single → latch the one-hot route into req_q and go to ACTIVE.
  - Head type is body or tail → pop and discard it, pulse drop_err, stay in IDLE.
- ACTIVE:
  - pop = |(req_q & gnt) & !empty.
  - On a pop whose flit type is tail or single: clear req_q and go to IDLE at the same edge.
  - Empty FIFO mid-packet: hold req, no pop, no timeout.
- out_valid = pop in ACTIVE only. Discards never assert out_valid.
- A grant on a bit where req_q=0 is ignored.
- The FIFO allows simultaneous push and pop when not full. Occupancy counter is $clog2(DEPTH+1) bits wide. Pointers wrap modulo DEPTH.
- Reset mid-packet: FIFO is flushed, req=0, IDLE. The arbiter also resets, so no grant is left dangling.

## Timing
- Reset values: in_ready=1, req=0, out_valid=0, drop_err=0. out_flit equals the FIFO RAM head and is don't-care while empty.
- req is registered (req_q). out_valid is combinational from state, gnt and empty.
- Head pushed at edge 0:
  - Visible at the FIFO head in cycle 1.
  - req high in cycle 2.
  - Arbiter grant (registered) high in cycle 3.
  - First out_valid in cycle 3.
- Body flits then transfer one per cycle.
- Tail popped at edge T:
  - req low in cycle T+1.
  - Arbiter gnt low in cycle T+2.
  - The next head can raise req in cycle T+2 at the earliest.
- The block never pops while req_q is low, so the stale grant in cycle T+1 is harmless.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.

## Structure
- Package `noc_pkg`:
  - Flit type codes (FT_BODY, FT_HEAD, FT_TAIL, FT_SINGLE).
  - Port indices (P_LOCAL=0, P_N=1, P_E=2, P_S=3, P_W=4).
  - Field offsets for dest X/Y.
  - Function `xy_route(dx,dy,cx,cy)` returning the 5-bit one-hot route.
- Sub-module `flit_fifo`: parameterised by FLIT_W and DEPTH. Ports push, pop, din, dout, empty, full.
- The FSM and route logic live in the top module.

## Test plan
- Single flit {11, X=3, Y=1} at CUR=(3,1), gnt follows req one cycle late → req=5'b00001 in cycle 2, out_valid in cycle 3, req=0 in cycle 4.
- Head (X=0,Y=1), 2 bodies, tail → req=5'b10000; out_valid on 4 consecutive cycles starting cycle 3; req drops the cycle after the tail pops.
- Route sweep over all 16 (X,Y) destinations at CUR=(3,1) → E never (X max is 3), W for X<3, N for X=3,Y>1, S for X=3,Y=0, local for (3,1).
- Gnt withheld 10 cycles while 5 flits are offered → FIFO fills after 4 pushes, in_ready=0, req stays asserted, no out_valid. On gnt, 4 flits pop in 4 cycles and in_ready returns.
- Body flit arrives with no preceding head → one drop_err pulse, no req, no out_valid. A following head is routed normally.
- rst asserted after 2 of 4 flits are sent → next cycle req=0, in_ready=1, FIFO empty. A fresh packet after reset routes from IDLE.
